ahb_mem_arbiter: RTL and testbench

Two-master arbiter and transfer sequencer for the shared memory path. It takes single-beat requests from the instruction-fetch master and the data master and grants one at a time. For the granted request it drives the shared address, control and write data, plus the RAM/ROM `muxsel` into the slave glue. It returns read data and response to the owning master as a one-cycle registered pulse.

---
 rtl/ahb_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ahb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_arbiter.sv
// ahb_mem_arbiter: two-master single-beat arbiter and transfer sequencer for the shared ROM/RAM path
//
// Grants one of two masters per transfer and drives the shared bus to the slave glue. Each transfer runs
// IDLE -> XFER -> RESP. The owner gets a one-cycle registered ready pulse, with its read data and error flag.
//
// Ports
//   hclk, hreset                clock (rising edge), asynchronous active-high reset
//   i_req/i_addr/i_prot         instruction master request (read only)
//   i_ready/i_resp/i_rdata      instruction master completion pulse, error flag, read data
//   d_req/d_addr/d_write/
//   d_wdata/d_prot              data master request
//   d_ready/d_resp/d_rdata      data master completion pulse, error flag, read data
//   haddr/hwdata/hwrite/hprot   shared bus towards the slave glue
//   muxsel                      1 = ROM path, 0 = RAM path
//   hrdata_rom/hrdata_ram       read data from each path
//   hready_inst/hresp_inst      ROM path ready and error
//   hready_data/hresp_data      RAM path ready and error
//
// Parameter TIMEOUT: consecutive low-hready cycles tolerated before the transfer ends with an error (>= 1).
// Macro ARB_ROUND_ROBIN_EN: when defined, contention grants the master that did not own the previous transfer.
// When undefined, the data master always wins.
module ahb_mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_prot,
  output logic        i_ready,
  output logic        i_resp,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_prot,
  output logic        d_ready,
  output logic        d_resp,
  output logic [31:0] d_rdata,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  output logic        hwrite,
  output logic [3:0]  hprot,
  output logic        muxsel,
  input  logic [31:0] hrdata_rom,
  input  logic [31:0] hrdata_ram,
  input  logic        hready_inst,
  input  logic        hresp_inst,
  input  logic        hready_data,
  input  logic        hresp_data
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  state_t        state;
  logic          owner_d;
  logic          last_d;
  logic [CW-1:0] wcnt;
  logic          grant_d;
  logic          rom_hit;
  logic          legal;
  logic [31:0]   req_addr;
  logic          sel_ready;
  logic          sel_resp;
  logic [31:0]   sel_rdata;
  logic          expired;
  logic          fin_resp;
  logic [31:0]   fin_rdata;
`ifdef ARB_ROUND_ROBIN_EN
  // on contention the master that did not own the previous transfer wins
  assign grant_d = d_req & (~i_req | ~last_d);
`else
  assign grant_d = d_req;
`endif
  assign req_addr  = grant_d ? d_addr : i_addr;
  assign rom_hit   = req_addr[31:24] == 8'hA0;
  assign legal     = rom_hit | (req_addr[31:24] == 8'hB0);
  assign sel_ready = muxsel ? hready_inst : hready_data;
  assign sel_resp  = muxsel ? hresp_inst : hresp_data;
  assign sel_rdata = muxsel ? hrdata_rom : hrdata_ram;
  // ready wins over the timeout, so a slave answering on the last allowed cycle still completes normally
  assign expired   = ~sel_ready & (wcnt == CW'(TIMEOUT));
  assign fin_resp  = sel_ready ? sel_resp : 1'b1;
  assign fin_rdata = sel_ready ? sel_rdata : '0;
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      last_d  <= 1'b1;
      wcnt    <= '0;
      haddr   <= '0;
      hwdata  <= '0;
      hwrite  <= 1'b0;
      hprot   <= '0;
      muxsel  <= 1'b0;
      i_ready <= 1'b0;
      i_resp  <= 1'b0;
      i_rdata <= '0;
      d_ready <= 1'b0;
      d_resp  <= 1'b0;
      d_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req | d_req) begin
            owner_d <= grant_d;
            last_d  <= grant_d;
            if (legal) begin
              haddr  <= req_addr;
              hwrite <= grant_d & d_write;
              hwdata <= grant_d ? d_wdata : '0;
              hprot  <= grant_d ? d_prot : i_prot;
              muxsel <= rom_hit;
              wcnt   <= '0;
              state  <= XFER;
            end else if (grant_d) begin
              // decode error: answer directly without touching the shared bus
              d_ready <= 1'b1;
              d_resp  <= 1'b1;
              d_rdata <= '0;
              state   <= RESP;
            end else begin
              i_ready <= 1'b1;
              i_resp  <= 1'b1;
              i_rdata <= '0;
              state   <= RESP;
            end
          end
        end
        XFER: begin
          if (sel_ready | expired) begin
            if (owner_d) begin
              d_ready <= 1'b1;
              d_resp  <= fin_resp;
              d_rdata <= fin_rdata;
            end else begin
              i_ready <= 1'b1;
              i_resp  <= fin_resp;
              i_rdata <= fin_rdata;
            end
            hwrite <= 1'b0;
            hwdata <= '0;
            wcnt   <= '0;
            state  <= RESP;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        RESP: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          hwrite  <= 1'b0;
          hwdata  <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// tb_ahb_mem_arbiter: table-driven, scoreboard-checked bench for ahb_mem_arbiter
module tb_ahb_mem_arbiter;
  localparam int TO = 16;
  logic        hclk = 1'b0;
  logic        hreset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [3:0]  i_prot = '0;
  logic        i_ready;
  logic        i_resp;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic        d_write = 1'b0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_prot = '0;
  logic        d_ready;
  logic        d_resp;
  logic [31:0] d_rdata;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [3:0]  hprot;
  logic        muxsel;
  logic [31:0] hrdata_rom = '0;
  logic [31:0] hrdata_ram = '0;
  logic        hready_inst = 1'b0;
  logic        hresp_inst = 1'b0;
  logic        hready_data = 1'b0;
  logic        hresp_data = 1'b0;

  always #5 hclk = ~hclk;

  ahb_mem_arbiter #(.TIMEOUT(TO)) dut (
    .hclk(hclk), .hreset(hreset),
    .i_req(i_req), .i_addr(i_addr), .i_prot(i_prot),
    .i_ready(i_ready), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata), .d_prot(d_prot),
    .d_ready(d_ready), .d_resp(d_resp), .d_rdata(d_rdata),
    .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .hprot(hprot), .muxsel(muxsel),
    .hrdata_rom(hrdata_rom), .hrdata_ram(hrdata_ram),
    .hready_inst(hready_inst), .hresp_inst(hresp_inst),
    .hready_data(hready_data), .hresp_data(hresp_data)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  prot;
    logic [31:0] rom;
    logic [31:0] ram;
    int          waits;
    logic        sresp;
    int          lat;
    logic        resp;
    logic        rd_chk;
    logic [31:0] rdata;
    logic        mux;
  } vec_t;

  typedef struct {
    logic        is_d;
    int          lat;
    logic        resp;
    logic        rd_chk;
    logic [31:0] rdata;
  } exp_t;

  vec_t        tv[10];
  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] bus_addr = '0;

  function automatic vec_t mk(input logic is_d, input logic [31:0] addr, input logic wr,
                              input logic [31:0] wdata, input logic [3:0] prot,
                              input logic [31:0] rom, input logic [31:0] ram, input int waits,
                              input logic sresp, input int lat, input logic resp,
                              input logic rd_chk, input logic [31:0] rdata, input logic mux);
    vec_t v;
    v.is_d = is_d; v.addr = addr; v.wr = wr; v.wdata = wdata; v.prot = prot;
    v.rom = rom; v.ram = ram; v.waits = waits; v.sresp = sresp; v.lat = lat;
    v.resp = resp; v.rd_chk = rd_chk; v.rdata = rdata; v.mux = mux;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    exp_t e;
    exp_t g;
    logic seen;
    logic rdy;
    @(negedge hclk);
    chk({tag, " idle i_ready"}, 32'(i_ready), 32'd0);
    chk({tag, " idle d_ready"}, 32'(d_ready), 32'd0);
    if (v.is_d) begin
      d_req = 1'b1; d_addr = v.addr; d_write = v.wr; d_wdata = v.wdata; d_prot = v.prot;
    end else begin
      i_req = 1'b1; i_addr = v.addr; i_prot = v.prot;
    end
    hrdata_rom = v.rom; hrdata_ram = v.ram;
    hready_inst = 1'b0; hready_data = 1'b0; hresp_inst = 1'b1; hresp_data = 1'b1;
    e.is_d = v.is_d; e.lat = v.lat; e.resp = v.resp; e.rd_chk = v.rd_chk; e.rdata = v.rdata;
    q.push_back(e);
    seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge hclk);
      if (n == 1) begin
        if (v.lat == 1) begin
          chk({tag, " derr haddr"}, haddr, bus_addr);
          chk({tag, " derr hwrite"}, 32'(hwrite), 32'd0);
        end else begin
          chk({tag, " haddr"}, haddr, v.addr);
          chk({tag, " muxsel"}, 32'(muxsel), 32'(v.mux));
          chk({tag, " hwrite"}, 32'(hwrite), 32'(v.is_d & v.wr));
          chk({tag, " hprot"}, 32'(hprot), 32'(v.prot));
          if (!v.is_d) chk({tag, " hwdata"}, hwdata, 32'd0);
          else if (v.wr) chk({tag, " hwdata"}, hwdata, v.wdata);
          bus_addr = v.addr;
        end
      end
      chk({tag, " other ready"}, 32'(v.is_d ? i_ready : d_ready), 32'd0);
      if (v.is_d ? d_ready : i_ready) begin
        seen = 1'b1;
        g = q.pop_front();
        chk({tag, " latency"}, 32'(n), 32'(g.lat));
        chk({tag, " owner"}, 32'(v.is_d), 32'(g.is_d));
        chk({tag, " resp"}, 32'(v.is_d ? d_resp : i_resp), 32'(g.resp));
        if (g.rd_chk) chk({tag, " rdata"}, v.is_d ? d_rdata : i_rdata, g.rdata);
        chk({tag, " resp hwrite"}, 32'(hwrite), 32'd0);
        if (v.is_d) d_req = 1'b0;
        else i_req = 1'b0;
      end else begin
        rdy = n > v.waits;
        if (v.mux) begin
          hready_inst = rdy; hresp_inst = rdy ? v.sresp : 1'b0;
        end else begin
          hready_data = rdy; hresp_data = rdy ? v.sresp : 1'b0;
        end
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s no ready: got none within 40 cycles want cycle %0d", tag, v.lat);
      q.delete();
      i_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms");
    $fatal(1);
  end

  initial begin
    exp_t g;
    int got;
    tv[0] = mk(1'b0, 32'hA000_0010, 1'b0, 32'h0, 4'h0, 32'h1234_5678, 32'h5555_AAAA, 0, 1'b0, 2, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
    tv[1] = mk(1'b1, 32'hB000_0004, 1'b1, 32'hDEAD_BEEF, 4'h3, 32'h0BAD_0BAD, 32'h600D_F00D, 0, 1'b0, 2, 1'b0, 1'b0, 32'h0, 1'b0);
    tv[2] = mk(1'b1, 32'hC000_0000, 1'b0, 32'h1111_1111, 4'h1, 32'h0BAD_0BAD, 32'h600D_F00D, 0, 1'b0, 1, 1'b1, 1'b0, 32'h0, 1'b0);
    tv[3] = mk(1'b1, 32'hB000_0100, 1'b0, 32'h0, 4'h2, 32'h0BAD_0BAD, 32'hCAFE_0001, 5, 1'b0, 7, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0);
    tv[4] = mk(1'b1, 32'hB000_0200, 1'b0, 32'h0, 4'h2, 32'h0BAD_0BAD, 32'hCAFE_0002, TO + 1, 1'b0, TO + 2, 1'b1, 1'b1, 32'h0, 1'b0);
    tv[5] = mk(1'b1, 32'hB000_0300, 1'b0, 32'h0, 4'h2, 32'h0BAD_0BAD, 32'hCAFE_0003, TO, 1'b0, TO + 2, 1'b0, 1'b1, 32'hCAFE_0003, 1'b0);
    tv[6] = mk(1'b0, 32'hA000_0020, 1'b0, 32'h0, 4'hF, 32'h8765_4321, 32'h0BAD_0BAD, 3, 1'b1, 5, 1'b1, 1'b1, 32'h8765_4321, 1'b1);
    tv[7] = mk(1'b0, 32'h0000_0000, 1'b0, 32'h0, 4'h0, 32'h1357_9BDF, 32'h0BAD_0BAD, 0, 1'b0, 1, 1'b1, 1'b0, 32'h0, 1'b0);
    tv[8] = mk(1'b0, 32'hA000_0030, 1'b0, 32'h0, 4'h5, 32'h1357_9BDF, 32'h0BAD_0BAD, TO + 1, 1'b0, TO + 2, 1'b1, 1'b1, 32'h0, 1'b1);
    tv[9] = mk(1'b1, 32'hA000_0040, 1'b0, 32'h0, 4'h6, 32'h2468_ACE0, 32'h0BAD_BEEF, 2, 1'b0, 4, 1'b0, 1'b1, 32'h2468_ACE0, 1'b1);

    #2 hreset = 1'b1;
    #2;
    chk("rst haddr", haddr, 32'd0);
    chk("rst hwdata", hwdata, 32'd0);
    chk("rst hwrite", 32'(hwrite), 32'd0);
    chk("rst hprot", 32'(hprot), 32'd0);
    chk("rst muxsel", 32'(muxsel), 32'd0);
    chk("rst i_ready", 32'(i_ready), 32'd0);
    chk("rst i_resp", 32'(i_resp), 32'd0);
    chk("rst i_rdata", i_rdata, 32'd0);
    chk("rst d_ready", 32'(d_ready), 32'd0);
    chk("rst d_resp", 32'(d_resp), 32'd0);
    chk("rst d_rdata", d_rdata, 32'd0);
    repeat (2) @(negedge hclk);
    hreset = 1'b0;

    for (int k = 0; k < 10; k++) run(tv[k], $sformatf("vec%0d", k));

    @(negedge hclk);
    d_req = 1'b1; d_addr = 32'hB000_0008; d_write = 1'b1; d_wdata = 32'hA5A5_A5A5; d_prot = 4'h0;
    hready_data = 1'b0; hready_inst = 1'b0;
    @(negedge hclk);
    chk("mid hwrite", 32'(hwrite), 32'd1);
    hreset = 1'b1;
    #1;
    chk("abort hwrite", 32'(hwrite), 32'd0);
    chk("abort hwdata", hwdata, 32'd0);
    chk("abort haddr", haddr, 32'd0);
    chk("abort muxsel", 32'(muxsel), 32'd0);
    d_req = 1'b0;
    @(negedge hclk);
    hreset = 1'b0;
    bus_addr = '0;
    repeat (4) begin
      @(negedge hclk);
      chk("abort no ready", 32'({i_ready, d_ready}), 32'd0);
    end
    run(tv[1], "post-abort");

    @(negedge hclk);
    hreset = 1'b1;
    @(negedge hclk);
    hreset = 1'b0;
    q.delete();
    @(negedge hclk);
    i_req = 1'b1; i_addr = 32'hA000_0050; i_prot = 4'h0;
    d_req = 1'b1; d_addr = 32'hB000_0060; d_write = 1'b0; d_prot = 4'h0;
    hrdata_rom = 32'h1111_0000; hrdata_ram = 32'h2222_0000;
    hready_inst = 1'b1; hready_data = 1'b1; hresp_inst = 1'b0; hresp_data = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      g.is_d = k[0];
`else
      g.is_d = 1'b1;
`endif
      g.lat = 0; g.resp = 1'b0; g.rd_chk = 1'b1;
      g.rdata = g.is_d ? 32'h2222_0000 : 32'h1111_0000;
      q.push_back(g);
    end
    got = 0;
    for (int n = 0; n < 40 && got < 4; n++) begin
      @(negedge hclk);
      if (i_ready | d_ready) begin
        g = q.pop_front();
        chk("arb both ready", 32'(i_ready & d_ready), 32'd0);
        chk("arb owner", 32'(d_ready), 32'(g.is_d));
        chk("arb rdata", d_ready ? d_rdata : i_rdata, g.rdata);
        got++;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("arb grants", 32'(got), 32'd4);
    repeat (4) begin
      @(negedge hclk);
      chk("arb quiet", 32'({i_ready, d_ready}), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
